// File: rtl/rdn_ctrl_multi.sv
// Rotation-detection control: round-robin dispatch to NUM_ENG shared-weight engines,
// in-order result return to the IRU, and drain/load/timeout sequencing of weight reloads.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// READY      | normal operation, dispatch allowed once weights are loaded
// DRAIN      | reload pending, no dispatch, waiting for in-flight jobs to pop
// WR_WEIGHTS | weight load in progress, bounded by WT_TIMEOUT
module rdn_ctrl_multi #(
   parameter int NUM_ENG    = 2,
   parameter int WT_TIMEOUT = 1024,
   parameter int ID_W       = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               heu_out_valid,
   output logic               in_ready,
   input  logic               load_weights,
   input  logic               weight_valid,
   output logic [NUM_ENG-1:0] start_eng,
   input  logic [NUM_ENG-1:0] eng_done,
   input  logic               iru_in_ready,
   output logic               out_valid,
   output logic [ID_W-1:0]    out_eng,
   output logic               wt_err,
   output logic               busy
);

   localparam int CNT_W = $clog2(NUM_ENG + 1);
   localparam int TMO_W = $clog2(WT_TIMEOUT);
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(WT_TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_READY,
      ST_DRAIN,
      ST_WR_WEIGHTS
   } state_t;

   state_t state, state_nxt;

   logic               weights_loaded;
   logic [NUM_ENG-1:0] busy_r, done_r;
   logic [NUM_ENG-1:0] busy_nxt, done_nxt;
   logic [ID_W-1:0]    fifo_mem [NUM_ENG];
   logic [ID_W-1:0]    head, tail, rr_ptr;
   logic [CNT_W-1:0]   count;
   logic [TMO_W-1:0]   tmo_cnt;

   logic            accept, pop, tmo_hit;
   logic [ID_W-1:0] sel;

   function automatic logic [ID_W-1:0] inc_wrap(input logic [ID_W-1:0] v);
      return (int'(v) == NUM_ENG - 1) ? '0 : v + ID_W'(1);
   endfunction

   function automatic logic [ID_W-1:0] pick_free(input logic [NUM_ENG-1:0] bsy,
                                                 input logic [ID_W-1:0]    ptr);
      logic [ID_W-1:0] res;
      logic            found;
      int              idx;
      res   = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_ENG; k++) begin
         idx = (int'(ptr) + k) % NUM_ENG;
         if (!found && !bsy[idx]) begin
            found = 1'b1;
            res   = ID_W'(idx);
         end
      end
      return res;
   endfunction

   always_comb begin
      in_ready  = 1'b0;
      accept    = 1'b0;
      sel       = pick_free(busy_r, rr_ptr);
      start_eng = '0;
      out_valid = 1'b0;
      out_eng   = '0;
      pop       = 1'b0;
      busy_nxt  = busy_r;
      done_nxt  = done_r | (eng_done & busy_r);
      tmo_hit   = (tmo_cnt == '0);
      busy      = (|busy_r) || (state != ST_READY);
      state_nxt = state;

      in_ready = (state == ST_READY) && weights_loaded && !load_weights && !(&busy_r);
      accept   = in_ready && heu_out_valid;
      if (accept) begin
         start_eng[sel] = 1'b1;
      end

      if (count != '0) begin
         out_eng   = fifo_mem[head];
         out_valid = done_r[head];
      end
      pop = out_valid && iru_in_ready;

      // an engine popped this cycle is only reusable next cycle: sel comes from busy_r
      if (pop) begin
         busy_nxt[head] = 1'b0;
         done_nxt[head] = 1'b0;
      end
      if (accept) begin
         busy_nxt[sel] = 1'b1;
      end

      case (state)
         ST_READY: begin
            if (load_weights) begin
               state_nxt = (|busy_r) ? ST_DRAIN : ST_WR_WEIGHTS;
            end
         end
         ST_DRAIN: begin
            if (busy_nxt == '0) begin
               state_nxt = ST_WR_WEIGHTS;
            end
         end
         ST_WR_WEIGHTS: begin
            if (weight_valid || tmo_hit) begin
               state_nxt = ST_READY;
            end
         end
         default: state_nxt = ST_READY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ST_READY;
         weights_loaded <= 1'b0;
         wt_err         <= 1'b0;
         busy_r         <= '0;
         done_r         <= '0;
         head           <= '0;
         tail           <= '0;
         rr_ptr         <= '0;
         count          <= '0;
         tmo_cnt        <= '0;
      end else begin
         state  <= state_nxt;
         busy_r <= busy_nxt;
         done_r <= done_nxt;

         if (accept) begin
            tail   <= inc_wrap(tail);
            rr_ptr <= inc_wrap(sel);
         end
         if (pop) begin
            head <= inc_wrap(head);
         end
         if (accept && !pop) begin
            count <= count + CNT_W'(1);
         end else if (!accept && pop) begin
            count <= count - CNT_W'(1);
         end

         tmo_cnt <= (state == ST_WR_WEIGHTS) ? tmo_cnt - TMO_W'(1) : TMO_LOAD;

         if (state != ST_WR_WEIGHTS && state_nxt == ST_WR_WEIGHTS) begin
            weights_loaded <= 1'b0;
         end
         // weight_valid coinciding with the timeout is treated as success
         if (state == ST_WR_WEIGHTS) begin
            if (weight_valid) begin
               weights_loaded <= 1'b1;
               wt_err         <= 1'b0;
            end else if (tmo_hit) begin
               wt_err <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         fifo_mem[tail] <= sel;
      end
   end

endmodule

// File: tb/tb_rdn_ctrl_multi.sv
// Directed bench for rdn_ctrl_multi (4 engines, timeout 8); issue order is
// queued by the stimulus and checked by an independent output monitor.
module tb_rdn_ctrl_multi;

   localparam int NE  = 4;
   localparam int TMO = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          heu_out_valid = 1'b0;
   logic          load_weights = 1'b0;
   logic          weight_valid = 1'b0;
   logic          iru_in_ready = 1'b1;
   logic [NE-1:0] eng_done = '0;
   logic [NE-1:0] start_eng;
   logic          in_ready, out_valid, wt_err, busy;
   logic [1:0]    out_eng;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         n_pop = 0;
   logic [1:0] exp_q [$];

   rdn_ctrl_multi #(.NUM_ENG(NE), .WT_TIMEOUT(TMO)) dut (
      .clk           (clk),
      .rst           (rst),
      .heu_out_valid (heu_out_valid),
      .in_ready      (in_ready),
      .load_weights  (load_weights),
      .weight_valid  (weight_valid),
      .start_eng     (start_eng),
      .eng_done      (eng_done),
      .iru_in_ready  (iru_in_ready),
      .out_valid     (out_valid),
      .out_eng       (out_eng),
      .wt_err        (wt_err),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   // issue one window in the current cycle; expects engine e to be launched
   task automatic issue(input int e);
      logic [NE-1:0] oh;
      oh = '0;
      oh[e] = 1'b1;
      heu_out_valid = 1'b1;
      #3;
      chk("issue_in_ready", 32'(in_ready), 32'd1);
      chk("issue_start_eng", 32'(start_eng), 32'(oh));
      exp_q.push_back(2'(e));
      next();
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && iru_in_ready) begin
         n_pop++;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pop_order: popped out_eng=%0d, expected no result", out_eng);
         end else begin
            chk("pop_order", 32'(out_eng), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      repeat (3) next();
      #3;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_start_eng", 32'(start_eng), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_eng", 32'(out_eng), 32'd0);
      chk("rst_wt_err", 32'(wt_err), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);

      // initial weight load, weight_valid five cycles after the request
      next();
      rst = 1'b0;
      load_weights = 1'b1;
      heu_out_valid = 1'b1;
      #3;
      chk("ld_in_ready", 32'(in_ready), 32'd0);
      chk("ld_start_eng", 32'(start_eng), 32'd0);
      next();
      load_weights = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         #3;
         chk("wr_in_ready", 32'(in_ready), 32'd0);
         chk("wr_busy", 32'(busy), 32'd1);
         next();
      end
      weight_valid = 1'b1;
      #3;
      chk("wr_in_ready", 32'(in_ready), 32'd0);
      next();
      weight_valid = 1'b0;
      heu_out_valid = 1'b0;
      #3;
      chk("loaded_in_ready", 32'(in_ready), 32'd1);
      chk("loaded_wt_err", 32'(wt_err), 32'd0);
      next();

      // back-to-back round-robin dispatch fills all engines
      issue(0);
      issue(1);
      issue(2);
      issue(3);
      #3;
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("full_start_eng", 32'(start_eng), 32'd0);
      heu_out_valid = 1'b0;
      next();

      // engine 2 finishes first and must wait behind 0 and 1
      eng_done = 4'b0100;
      #3;
      next();
      eng_done = '0;
      repeat (3) begin
         #3;
         chk("ooo_hold", 32'(out_valid), 32'd0);
         next();
      end
      eng_done = 4'b0001;
      #3;
      chk("ooo_hold", 32'(out_valid), 32'd0);
      next();
      eng_done = 4'b0010;
      #3;
      chk("head0_valid", 32'(out_valid), 32'd1);
      chk("head0_eng", 32'(out_eng), 32'd0);
      next();
      eng_done = '0;
      next();
      next();
      #3;
      chk("head3_not_done", 32'(out_valid), 32'd0);

      // IRU back-pressure for 10 cycles on engine 3's result
      iru_in_ready = 1'b0;
      eng_done = 4'b1000;
      next();
      eng_done = '0;
      repeat (10) begin
         #3;
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_eng", 32'(out_eng), 32'd3);
         next();
      end
      iru_in_ready = 1'b1;
      next();
      #3;
      chk("idle_valid", 32'(out_valid), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      next();

      // reload with three jobs in flight: drain, then time out
      issue(0);
      issue(1);
      issue(2);
      load_weights = 1'b1;
      #3;
      chk("ldwins_in_ready", 32'(in_ready), 32'd0);
      chk("ldwins_start", 32'(start_eng), 32'd0);
      next();
      load_weights = 1'b0;
      eng_done = 4'b0111;
      #3;
      chk("drain_in_ready", 32'(in_ready), 32'd0);
      chk("drain_start", 32'(start_eng), 32'd0);
      next();
      eng_done = '0;
      for (int k = 0; k < 3; k++) begin
         #3;
         chk("drain_valid", 32'(out_valid), 32'd1);
         chk("drain_eng", 32'(out_eng), 32'(k));
         chk("drain_in_ready", 32'(in_ready), 32'd0);
         next();
      end
      for (int k = 0; k < TMO; k++) begin
         #3;
         chk("tmo_wt_err_low", 32'(wt_err), 32'd0);
         chk("tmo_in_ready", 32'(in_ready), 32'd0);
         chk("tmo_busy", 32'(busy), 32'd1);
         next();
      end
      heu_out_valid = 1'b0;
      #3;
      chk("tmo_wt_err_high", 32'(wt_err), 32'd1);
      chk("tmo_after_in_ready", 32'(in_ready), 32'd0);
      chk("tmo_after_busy", 32'(busy), 32'd0);

      // weight_valid exactly on the timeout cycle still succeeds
      load_weights = 1'b1;
      next();
      load_weights = 1'b0;
      for (int k = 0; k < TMO - 1; k++) begin
         #3;
         chk("reload_wt_err_held", 32'(wt_err), 32'd1);
         next();
      end
      weight_valid = 1'b1;
      #3;
      chk("reload_wt_err_held", 32'(wt_err), 32'd1);
      next();
      weight_valid = 1'b0;
      #3;
      chk("reload_wt_err_clr", 32'(wt_err), 32'd0);
      chk("reload_in_ready", 32'(in_ready), 32'd1);
      chk("reload_busy", 32'(busy), 32'd0);
      next();

      // round-robin pointer continues after engine 2
      issue(3);
      heu_out_valid = 1'b0;
      eng_done = 4'b1000;
      #3;
      next();
      eng_done = '0;
      #3;
      chk("last_valid", 32'(out_valid), 32'd1);
      chk("last_eng", 32'(out_eng), 32'd3);
      next();
      next();
      #3;
      chk("end_queue_empty", 32'(exp_q.size()), 32'd0);
      chk("end_pop_count", 32'(n_pop), 32'd8);
      chk("end_busy", 32'(busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
